dnn_train_sequencer: RTL
========================

Name: dnn_train_sequencer

Overview:
- Controller that sequences training of the DNN core: holds a small bank of 1b training cases, picks one per pass, and streams its act/ideal-output slices into the network's act_in/y_in ports over cpc cycles.
- Accumulates |dL| per case and per epoch, and reports epoch error.
- Replaces testbench-side mux/select logic so training can run self-contained in hardware.

Parameters:
- WIDTH, 16, fixed-point width of dL from the DNN
- N_IN, 16, input neurons n[0]
- N_OUT, 4, output neurons n[L-1]
- A_SLICE, 4, act bits fed per clock (z[0]/fo[0])
- Y_SLICE, 1, ideal-output bits fed per clock (z[L-2]/fi[L-2])
- CASES, 8, training cases stored; power of 2
- EPOCH_LEN, 8, cases per reported epoch
- PAD_CYC, 2, idle cycles after slices (cpc = SLICES+PAD_CYC)
- ACC_W, 24, unsigned epoch accumulator width
- LFSR_SEED, 16'hACE1, nonzero LFSR seed

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  pulse; begin training (accepted in IDLE only)
- stop  in  1  request halt at end of current case
- wr_en  in  1  case-bank write (accepted in IDLE only)
- wr_idx  in  clog2(CASES)  case index to write
- wr_act  in  N_IN  act pattern
- wr_y  in  N_OUT  ideal output pattern
- dl_in  in  WIDTH  signed dL from DNN output layer
- act_in  out  A_SLICE  act slice to DNN
- y_in  out  Y_SLICE  ideal-output slice to DNN
- busy  out  1  high outside IDLE
- case_idx  out  clog2(CASES)  case currently fed
- epoch_err  out  ACC_W  last completed epoch error, held
- epoch_valid  out  1  one-cycle pulse when epoch_err updates
- epoch_cnt  out  16  completed epochs, wraps

Behaviour:
- Constraint: SLICES = N_IN/A_SLICE = N_OUT/Y_SLICE. Mismatch is an elaboration error.
- Reset (reset=0 at clk edge) clears the following to 0: all outputs, the case bank, the state (goes to IDLE), and the accumulators. The LFSR loads LFSR_SEED. Reset mid-pass aborts with no epoch_valid.
- States and transitions:
  - IDLE: start && !stop selects the first case and moves to FEED next cycle. start && stop stays in IDLE.
  - FEED: slice counter k runs 0..SLICES-1. act_in = act[k*A_SLICE +: A_SLICE]; y_in = y[k*Y_SLICE +: Y_SLICE]. Each cycle adds abs(dl_in) to case_err. abs(-2^(WIDTH-1)) = 2^(WIDTH-1)-1. After k=SLICES-1, go to PAD.
  - PAD: runs PAD_CYC cycles with act_in=0 and y_in=0, no accumulation.
    - On the last PAD cycle, epoch_acc += case_err (saturating at 2^ACC_W-1), case_err clears, and cases_done increments.
    - If cases_done reaches EPOCH_LEN, go to REPORT.
    - Otherwise, if stop is latched, go to IDLE and clear epoch_acc.
    - Otherwise pick the next case and go to FEED.
  - REPORT: one cycle. epoch_err <= epoch_acc, epoch_valid=1, epoch_cnt++, accumulators clear. Then go to IDLE if stop is latched, else pick a case and go to FEED.
- Cycles per case = SLICES+PAD_CYC (cpc); REPORT adds 1 cycle per epoch.
- stop is latched whenever busy and cleared on entering IDLE. A partial epoch is discarded, with no pulse.
- start while busy is ignored. wr_en while busy is ignored.
- case_idx is stable for the whole case (FEED through PAD).
- case_err width is WIDTH+clog2(SLICES) bits; it cannot overflow.

Optional Feature:
- DNN_SEQ_LFSR_EN defined: case pick = low clog2(CASES) bits of a 16-bit Fibonacci LFSR (taps 16,14,13,11). The LFSR advances once per pick.
- DNN_SEQ_LFSR_EN undefined: round-robin. The first pick after start is 0, then it increments mod CASES. The counter resets to 0 on every start.

Decomposition:
- Package dnn_seq_pkg:
  - state enum {IDLE, FEED, PAD, REPORT}
  - LFSR tap constant
  - abs/saturate function
- Sub-module dnn_seq_case_bank: CASES x (N_IN+N_OUT) register file. Synchronous write, combinational read by case_idx, plus slice muxing.

Test Plan:
- Round-robin, case 0 = {act 16'h000f, y 4'b0001}, start → act_in sequence f,0,0,0 then 0,0; y_in 1,0,0,0,0,0; busy rises 1 cycle after start.
- Load 8 cases, dl_in held at 16'hFC00 (-1.0) → each case_err = 0x1000; epoch_valid pulses after 8*6+1 = 49 busy cycles; epoch_err = 0x8000; epoch_cnt = 1.
- ACC_W=16, dl_in = 16'h8000 → per-cycle add 0x7FFF; epoch_err saturates at 0xFFFF with no wrap.
- stop pulsed mid-FEED of case 3 → case 3 completes its PAD, then IDLE; no epoch_valid; epoch_err keeps its prior value; next start restarts at case 0 (round-robin).
- reset deasserted-low asserted during PAD → next cycle IDLE, outputs 0, case bank cleared (act_in=0 after restart); wr_en during busy leaves bank unchanged.
- With DNN_SEQ_LFSR_EN, seed 16'hACE1 → case_idx sequence matches reference LFSR model over 64 picks.

Source files
------------

// File: rtl/dnn_seq_pkg.sv
// Shared types and helpers for the DNN training sequencer.
package dnn_seq_pkg;

  typedef enum logic [1:0] {IDLE, FEED, PAD, REPORT} seq_state_t;

  // Fibonacci feedback taps 16,14,13,11 as a mask over the shift register
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

  // Magnitude of a sign-extended w-bit value, clamped to the positive range of w bits
  function automatic logic [63:0] abs_clamp(input logic signed [63:0] v, input int unsigned w);
    logic [63:0] lim;
    logic [63:0] mag;
    lim = (64'd1 << (w - 1)) - 64'd1;
    mag = (v < 0) ? 64'(-v) : 64'(v);
    return (mag > lim) ? lim : mag;
  endfunction

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] s;
    logic [64:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    return (s > lim) ? lim[63:0] : s[63:0];
  endfunction

endpackage

// File: rtl/dnn_seq_case_bank.sv
// Training-case register file with per-slice readout of the selected case.
module dnn_seq_case_bank
  import dnn_seq_pkg::*;
#(
  parameter int N_IN    = 16,
  parameter int N_OUT   = 4,
  parameter int A_SLICE = 4,
  parameter int Y_SLICE = 1,
  parameter int CASES   = 8,
  parameter int K_W     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(CASES)-1:0] wr_idx,
  input  logic [N_IN-1:0]          wr_act,
  input  logic [N_OUT-1:0]         wr_y,
  input  logic [$clog2(CASES)-1:0] rd_idx,
  input  logic [K_W-1:0]           slice_k,
  input  logic                     slice_en,
  output logic [A_SLICE-1:0]       act_slice,
  output logic [Y_SLICE-1:0]       y_slice
);

  logic [N_IN-1:0]  act_mem [CASES];
  logic [N_OUT-1:0] y_mem   [CASES];
  logic [N_IN-1:0]  act_sel;
  logic [N_OUT-1:0] y_sel;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < CASES; i++) begin
        act_mem[i] <= '0;
        y_mem[i]   <= '0;
      end
    end else if (wr_en) begin
      act_mem[wr_idx] <= wr_act;
      y_mem[wr_idx]   <= wr_y;
    end
  end

  always_comb begin
    act_sel   = act_mem[rd_idx];
    y_sel     = y_mem[rd_idx];
    act_slice = '0;
    y_slice   = '0;
    if (slice_en) begin
      act_slice = act_sel[slice_k*A_SLICE +: A_SLICE];
      y_slice   = y_sel[slice_k*Y_SLICE +: Y_SLICE];
    end
  end

endmodule

// File: rtl/dnn_train_sequencer.sv
// Sequences training cases into the DNN core and accumulates per-epoch |dL|.
// Define DNN_SEQ_LFSR_EN for LFSR case selection; default is round-robin.
module dnn_train_sequencer
  import dnn_seq_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter int          N_IN      = 16,
  parameter int          N_OUT     = 4,
  parameter int          A_SLICE   = 4,
  parameter int          Y_SLICE   = 1,
  parameter int          CASES     = 8,
  parameter int          EPOCH_LEN = 8,
  parameter int          PAD_CYC   = 2,
  parameter int          ACC_W     = 24,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     wr_en,
  input  logic [$clog2(CASES)-1:0] wr_idx,
  input  logic [N_IN-1:0]          wr_act,
  input  logic [N_OUT-1:0]         wr_y,
  input  logic signed [WIDTH-1:0]  dl_in,
  output logic [A_SLICE-1:0]       act_in,
  output logic [Y_SLICE-1:0]       y_in,
  output logic                     busy,
  output logic [$clog2(CASES)-1:0] case_idx,
  output logic [ACC_W-1:0]         epoch_err,
  output logic                     epoch_valid,
  output logic [15:0]              epoch_cnt
);

  localparam int SLICES = N_IN / A_SLICE;
  localparam int IDX_W  = $clog2(CASES);
  localparam int K_W    = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int P_W    = (PAD_CYC > 1) ? $clog2(PAD_CYC) : 1;
  localparam int CE_W   = WIDTH + $clog2(SLICES);
  localparam int D_W    = $clog2(EPOCH_LEN + 1);

  if ((N_IN % A_SLICE != 0) || (N_OUT % Y_SLICE != 0) ||
      (N_IN / A_SLICE != N_OUT / Y_SLICE)) begin : g_slice_err
    $error("dnn_train_sequencer: N_IN/A_SLICE must equal N_OUT/Y_SLICE");
  end
  if ((CASES < 2) || ((CASES & (CASES - 1)) != 0)) begin : g_cases_err
    $error("dnn_train_sequencer: CASES must be a power of 2");
  end
  if ((LFSR_SEED == 16'h0000) || (PAD_CYC < 1) || (EPOCH_LEN < 1)) begin : g_misc_err
    $error("dnn_train_sequencer: LFSR_SEED must be nonzero, PAD_CYC/EPOCH_LEN >= 1");
  end

  seq_state_t       state, state_n;
  logic [K_W-1:0]   k_cnt;
  logic [P_W-1:0]   pad_cnt;
  logic [CE_W-1:0]  case_err;
  logic [ACC_W-1:0] epoch_acc;
  logic [D_W-1:0]   cases_done;
  logic             stop_lat;
  logic [IDX_W-1:0] pick_idx;

  logic k_last, pad_last, epoch_full, stop_req;
  logic do_pick, from_start, case_end, abandon;
  logic feed_en, bank_we;

  assign k_last     = (k_cnt == K_W'(SLICES - 1));
  assign pad_last   = (pad_cnt == P_W'(PAD_CYC - 1));
  assign epoch_full = (cases_done == D_W'(EPOCH_LEN - 1));
  assign stop_req   = stop_lat | stop;

`ifdef DNN_SEQ_LFSR_EN
  logic [15:0] lfsr;
  assign pick_idx = lfsr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset)       lfsr <= LFSR_SEED;
    else if (do_pick) lfsr <= lfsr_next(lfsr);
  end
`else
  assign pick_idx = from_start ? '0 : case_idx + IDX_W'(1);
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    do_pick    = 1'b0;
    from_start = 1'b0;
    case_end   = 1'b0;
    abandon    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n    = FEED;
          do_pick    = 1'b1;
          from_start = 1'b1;
        end
      end
      FEED: if (k_last) state_n = PAD;
      PAD: begin
        if (pad_last) begin
          case_end = 1'b1;
          if (epoch_full) begin
            state_n = REPORT;
          end else if (stop_req) begin
            state_n = IDLE;
            abandon = 1'b1;
          end else begin
            state_n = FEED;
            do_pick = 1'b1;
          end
        end
      end
      REPORT: begin
        if (stop_req) begin
          state_n = IDLE;
        end else begin
          state_n = FEED;
          do_pick = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    feed_en = (state == FEED);
    bank_we = wr_en && (state == IDLE);
  end

  // A partial epoch abandoned by stop never reaches epoch_acc's consumers
  always_ff @(posedge clk) begin
    if (!reset) begin
      k_cnt       <= '0;
      pad_cnt     <= '0;
      case_err    <= '0;
      epoch_acc   <= '0;
      cases_done  <= '0;
      stop_lat    <= 1'b0;
      case_idx    <= '0;
      epoch_err   <= '0;
      epoch_valid <= 1'b0;
      epoch_cnt   <= '0;
    end else begin
      stop_lat    <= busy && (state_n != IDLE) && stop_req;
      epoch_valid <= (state == REPORT);
      if (do_pick) case_idx <= pick_idx;
      if (state == FEED) begin
        k_cnt    <= k_last ? '0 : k_cnt + K_W'(1);
        case_err <= case_err + CE_W'(abs_clamp(64'(dl_in), WIDTH));
      end
      if (state == PAD) pad_cnt <= pad_last ? '0 : pad_cnt + P_W'(1);
      if (case_end) begin
        case_err <= '0;
        if (abandon) begin
          epoch_acc  <= '0;
          cases_done <= '0;
        end else begin
          epoch_acc  <= ACC_W'(sat_add(64'(epoch_acc), 64'(case_err), ACC_W));
          cases_done <= cases_done + D_W'(1);
        end
      end
      if (state == REPORT) begin
        epoch_err  <= epoch_acc;
        epoch_cnt  <= epoch_cnt + 16'd1;
        epoch_acc  <= '0;
        cases_done <= '0;
      end
    end
  end

  dnn_seq_case_bank #(
    .N_IN    (N_IN),
    .N_OUT   (N_OUT),
    .A_SLICE (A_SLICE),
    .Y_SLICE (Y_SLICE),
    .CASES   (CASES),
    .K_W     (K_W)
  ) u_bank (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (bank_we),
    .wr_idx    (wr_idx),
    .wr_act    (wr_act),
    .wr_y      (wr_y),
    .rd_idx    (case_idx),
    .slice_k   (k_cnt),
    .slice_en  (feed_en),
    .act_slice (act_in),
    .y_slice   (y_in)
  );

endmodule
